jk_ff_monitor: RTL and testbench
================================

JK_FF_MONITOR -- requirements
Module: jk_ff_monitor

Interface
REQ-001 Parameter CNT_W, default 8, sets the width of the check and error counters.
REQ-002 Parameter STOP_ON_ERR, default 0; when 1, the first mismatch halts checking.
REQ-003 clk  input  1  single clock; all sampling on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  sampling enable; 0 pauses the monitor without losing state.
REQ-006 clr  input  1  synchronous clear of counters, flags and sync state; priority over en.
REQ-007 jk  input  2  excitation observed at the flip-flop under test (jk[1]=J, jk[0]=K).
REQ-008 q  input  1  observed flip-flop output.
REQ-009 qb  input  1  observed complementary output.
REQ-010 check_cnt  output  CNT_W  number of comparisons performed; saturates at all-ones.
REQ-011 err_cnt  output  CNT_W  number of mismatches; saturates at all-ones.
REQ-012 err_pulse  output  1  one-cycle pulse on the cycle a mismatch is detected.
REQ-013 err_sticky  output  1  high from the first mismatch until reset or clr.
REQ-014 first_exp  output  1  expected q at the first mismatch.
REQ-015 first_jk  output  2  jk value that produced first_exp.
REQ-016 busy  output  1  high in SYNC and CHECK states.

Function
REQ-017 The FSM SHALL have states IDLE, SYNC, CHECK and HALT.
REQ-018 IDLE -> SYNC on the first posedge with en=1; no comparison is made on that edge.
REQ-019 In SYNC, on an en=1 edge the monitor SHALL register the sampled q and jk, compute exp_q, and move to CHECK.
REQ-020 exp_q SHALL follow the JK function: 00 -> q held, 01 -> 0, 10 -> 1, 11 -> ~q (all relative to the q sampled with that jk).
REQ-021 In CHECK, each en=1 edge SHALL compare the sampled q against exp_q and sampled qb against ~q, increment check_cnt, then recompute exp_q from the current jk and q.
REQ-022 A mismatch (q != exp_q or qb != ~q) SHALL assert err_pulse on the following cycle and increment err_cnt.
REQ-023 On the first mismatch since reset/clr, first_exp and first_jk SHALL be captured and err_sticky set; later mismatches leave them unchanged.
REQ-024 On a mismatch with STOP_ON_ERR=1, the FSM SHALL enter HALT: counters freeze and busy=0; only reset or clr leaves HALT.
REQ-025 On a mismatch with STOP_ON_ERR=0, the FSM SHALL stay in CHECK and resynchronise by using the observed q as the base for the next expectation.
REQ-026 An en=0 edge SHALL neither compare nor update exp_q; the next en=1 edge SHALL re-enter SYNC, because flip-flop edges were missed.
REQ-027 clr=1 SHALL zero the counters and capture registers, clear err_sticky and return to IDLE; err_pulse=0 that cycle.
REQ-028 Counters SHALL saturate at 2^CNT_W-1 and never wrap; a simultaneous check and error increment both counters in the same cycle.

Reset
REQ-029 On reset: state=IDLE, check_cnt=0, err_cnt=0, err_pulse=0, err_sticky=0, first_exp=0, first_jk=2'b00, busy=0.
REQ-030 Reset asserted mid-CHECK SHALL take effect immediately, without waiting for clk, and discard any pending comparison.

Structure
REQ-031 State encoding and the JK opcode constants (HOLD=00, RST=01, SET=10, TOG=11) SHALL live in a shared package used by the flip-flop and this monitor.
REQ-032 The next-state function SHALL be a sub-module jk_next (inputs jk and q, output exp_q), reusable by other checkers.

Verification
REQ-033 Bench with a clean JK flip-flop, jk sequence 00,01,10,11,11 at one per cycle -> err_cnt=0, check_cnt=4, err_sticky=0.
REQ-034 q forced to 0 after SET (10) -> err_pulse one cycle, err_cnt=1, first_jk=2'b10, first_exp=1.
REQ-035 qb tied equal to q, STOP_ON_ERR=1 -> first check fails, state HALT, counters frozen for 10 further cycles.
REQ-036 CNT_W=2 with 6 forced toggle errors -> err_cnt=3 and check_cnt=3, no wrap.
REQ-037 en dropped for 3 cycles mid-run, then restored -> no false error; check_cnt resumes after one SYNC edge.
REQ-038 reset pulsed between clock edges during CHECK -> all outputs at reset values before the next posedge.

Source files
------------

// File: rtl/jk_ff_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jk_ff_monitor_pkg
// Description : JK opcode encodings and monitor state encodings shared by the
//               flip-flop model, jk_next and jk_ff_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package jk_ff_monitor_pkg;

    localparam logic [1:0] c_JK_HOLD = 2'b00;
    localparam logic [1:0] c_JK_RST  = 2'b01;
    localparam logic [1:0] c_JK_SET  = 2'b10;
    localparam logic [1:0] c_JK_TOG  = 2'b11;

    localparam int unsigned c_ST_W = 2;

    localparam logic [c_ST_W-1:0] c_ST_IDLE  = 2'd0;
    localparam logic [c_ST_W-1:0] c_ST_SYNC  = 2'd1;
    localparam logic [c_ST_W-1:0] c_ST_CHECK = 2'd2;
    localparam logic [c_ST_W-1:0] c_ST_HALT  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/jk_next.sv
`default_nettype none
// ============================================================================
// Module      : jk_next
// Description : Combinational JK next-state function: exp_q is the value q
//               takes after one clock with excitation jk.
// Revision    : 1.0 - initial release
// ============================================================================
module jk_next
    import jk_ff_monitor_pkg::*;
(
    input  logic [1:0] jk,
    input  logic       q,
    output logic       exp_q
);

    always_comb begin
        exp_q = q;
        case (jk)
            c_JK_HOLD: exp_q = q;
            c_JK_RST:  exp_q = 1'b0;
            c_JK_SET:  exp_q = 1'b1;
            c_JK_TOG:  exp_q = ~q;
            default:   exp_q = q;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/jk_ff_monitor.sv
`default_nettype none
// ============================================================================
// Module      : jk_ff_monitor
// Description : Checks an observed JK flip-flop against its next-state
//               function; counts checks and mismatches, records the first.
// Revision    : 1.0 - initial release
// ============================================================================
module jk_ff_monitor
    import jk_ff_monitor_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [1:0]       jk,
    input  logic             q,
    input  logic             qb,
    output logic [CNT_W-1:0] check_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic             first_exp,
    output logic [1:0]       first_jk,
    output logic             busy
);

    logic [c_ST_W-1:0] r_state;
    logic [c_ST_W-1:0] w_state_nxt;

    logic             r_exp_q;
    logic [1:0]       r_exp_jk;
    logic [CNT_W-1:0] r_check_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic             r_err_pulse;
    logic             r_err_sticky;
    logic             r_first_exp;
    logic [1:0]       r_first_jk;

    logic w_exp_q;
    logic w_mismatch;
    logic w_check;
    logic w_sync;
    logic w_err;

    jk_next u_jk_next (
        .jk    (jk),
        .q     (q),
        .exp_q (w_exp_q)
    );

    assign w_mismatch = (q != r_exp_q) || (qb == q);
    assign w_check    = (r_state == c_ST_CHECK) && en;
    assign w_sync     = (r_state == c_ST_SYNC) && en;
    assign w_err      = w_check && w_mismatch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A paused CHECK drops back to SYNC: flip-flop edges were missed.
    always_comb begin
        w_state_nxt = r_state;
        if (clr) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE:  if (en) w_state_nxt = c_ST_SYNC;
                c_ST_SYNC:  if (en) w_state_nxt = c_ST_CHECK;
                c_ST_CHECK: begin
                    if (!en) begin
                        w_state_nxt = c_ST_SYNC;
                    end else if (w_mismatch && STOP_ON_ERR) begin
                        w_state_nxt = c_ST_HALT;
                    end
                end
                c_ST_HALT:  w_state_nxt = c_ST_HALT;
                default:    w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    // Next expectation is always rebuilt from the observed q, which also
    // resynchronises the monitor after a mismatch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_exp_q      <= 1'b0;
            r_exp_jk     <= 2'b00;
            r_check_cnt  <= '0;
            r_err_cnt    <= '0;
            r_err_pulse  <= 1'b0;
            r_err_sticky <= 1'b0;
            r_first_exp  <= 1'b0;
            r_first_jk   <= 2'b00;
        end else if (clr) begin
            r_exp_q      <= 1'b0;
            r_exp_jk     <= 2'b00;
            r_check_cnt  <= '0;
            r_err_cnt    <= '0;
            r_err_pulse  <= 1'b0;
            r_err_sticky <= 1'b0;
            r_first_exp  <= 1'b0;
            r_first_jk   <= 2'b00;
        end else begin
            r_err_pulse <= w_err;
            if (w_sync || (w_check && (w_state_nxt != c_ST_HALT))) begin
                r_exp_q  <= w_exp_q;
                r_exp_jk <= jk;
            end
            if (w_check && (r_check_cnt != '1)) begin
                r_check_cnt <= r_check_cnt + 1'b1;
            end
            if (w_err && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
            if (w_err && !r_err_sticky) begin
                r_err_sticky <= 1'b1;
                r_first_exp  <= r_exp_q;
                r_first_jk   <= r_exp_jk;
            end
        end
    end

    assign check_cnt  = r_check_cnt;
    assign err_cnt    = r_err_cnt;
    assign err_pulse  = r_err_pulse;
    assign err_sticky = r_err_sticky;
    assign first_exp  = r_first_exp;
    assign first_jk   = r_first_jk;
    assign busy       = (r_state == c_ST_SYNC) || (r_state == c_ST_CHECK);

endmodule
`default_nettype wire

// File: tb/tb_jk_ff_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_jk_ff_monitor
// Description : Self-checking bench for jk_ff_monitor (default, halting and
//               narrow-counter instances) driven by a JK flip-flop model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_ff_monitor;
    import jk_ff_monitor_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // default instance
    logic       en_a, clr_a, q_a, qb_a;
    logic [1:0] jk_a;
    logic [7:0] chk_a, err_a;
    logic       pulse_a, sticky_a, fexp_a, busy_a;
    logic [1:0] fjk_a;

    // halting instance, qb tied equal to q
    logic       en_h, clr_h, q_h, qb_h;
    logic [1:0] jk_h;
    logic [7:0] chk_h, err_h;
    logic       pulse_h, sticky_h, fexp_h, busy_h;
    logic [1:0] fjk_h;

    // 2-bit counter instance, flip-flop stuck while toggling
    logic       en_s, clr_s, q_s, qb_s;
    logic [1:0] jk_s;
    logic [1:0] chk_s, err_s;
    logic       pulse_s, sticky_s, fexp_s, busy_s;
    logic [1:0] fjk_s;

    jk_ff_monitor #(.CNT_W(8), .STOP_ON_ERR(1'b0)) dut_a (
        .clk(clk), .reset(reset), .en(en_a), .clr(clr_a), .jk(jk_a), .q(q_a), .qb(qb_a),
        .check_cnt(chk_a), .err_cnt(err_a), .err_pulse(pulse_a), .err_sticky(sticky_a),
        .first_exp(fexp_a), .first_jk(fjk_a), .busy(busy_a)
    );

    jk_ff_monitor #(.CNT_W(8), .STOP_ON_ERR(1'b1)) dut_h (
        .clk(clk), .reset(reset), .en(en_h), .clr(clr_h), .jk(jk_h), .q(q_h), .qb(qb_h),
        .check_cnt(chk_h), .err_cnt(err_h), .err_pulse(pulse_h), .err_sticky(sticky_h),
        .first_exp(fexp_h), .first_jk(fjk_h), .busy(busy_h)
    );

    jk_ff_monitor #(.CNT_W(2), .STOP_ON_ERR(1'b0)) dut_s (
        .clk(clk), .reset(reset), .en(en_s), .clr(clr_s), .jk(jk_s), .q(q_s), .qb(qb_s),
        .check_cnt(chk_s), .err_cnt(err_s), .err_pulse(pulse_s), .err_sticky(sticky_s),
        .first_exp(fexp_s), .first_jk(fjk_s), .busy(busy_s)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic jk_f(input logic [1:0] jk, input logic q);
        case (jk)
            c_JK_HOLD: return q;
            c_JK_RST:  return 1'b0;
            c_JK_SET:  return 1'b1;
            default:   return ~q;
        endcase
    endfunction

    // Reference model of the default instance
    typedef struct {
        logic [7:0] chk;
        logic [7:0] err;
        logic       pulse;
        logic       sticky;
        logic       busy;
        logic       fexp;
        logic [1:0] fjk;
    } exp_t;

    exp_t sbq[$];

    int         m_state;   // 0 idle, 1 sync, 2 check
    logic       m_exp;
    logic [1:0] m_ejk;
    int         m_chk, m_err;
    logic       m_pulse, m_sticky, m_fexp;
    logic [1:0] m_fjk;
    logic       q_ff;

    task automatic model_reset();
        m_state = 0; m_exp = 1'b0; m_ejk = 2'b00; m_chk = 0; m_err = 0;
        m_pulse = 1'b0; m_sticky = 1'b0; m_fexp = 1'b0; m_fjk = 2'b00;
    endtask

    task automatic model_edge(input logic en, input logic clr, input logic [1:0] jk,
                              input logic q, input logic qb);
        logic mm;
        if (clr) begin
            model_reset();
            return;
        end
        m_pulse = 1'b0;
        case (m_state)
            0: if (en) m_state = 1;
            1: if (en) begin
                   m_exp = jk_f(jk, q); m_ejk = jk; m_state = 2;
               end
            default: begin
                if (!en) begin
                    m_state = 1;
                end else begin
                    mm = (q != m_exp) || (qb != ~q);
                    if (m_chk < 255) m_chk++;
                    if (mm) begin
                        m_pulse = 1'b1;
                        if (m_err < 255) m_err++;
                        if (!m_sticky) begin
                            m_sticky = 1'b1; m_fexp = m_exp; m_fjk = m_ejk;
                        end
                    end
                    m_exp = jk_f(jk, q); m_ejk = jk;
                end
            end
        endcase
    endtask

    // flt: 0 none, 1 force flip-flop to 0 after the edge, 2 force to 1
    task automatic step(input logic [1:0] jkv, input logic env, input logic clrv, input int flt);
        exp_t e;
        @(negedge clk);
        jk_a = jkv; en_a = env; clr_a = clrv; q_a = q_ff; qb_a = ~q_ff;
        model_edge(env, clrv, jkv, q_ff, ~q_ff);
        e.chk = 8'(m_chk); e.err = 8'(m_err); e.pulse = m_pulse; e.sticky = m_sticky;
        e.busy = (m_state == 1) || (m_state == 2); e.fexp = m_fexp; e.fjk = m_fjk;
        sbq.push_back(e);
        @(posedge clk);
        q_ff = jk_f(jkv, q_ff);
        if (flt == 1) q_ff = 1'b0;
        if (flt == 2) q_ff = 1'b1;
        #1;
        e = sbq.pop_front();
        chk_val("check_cnt", 32'(chk_a), 32'(e.chk));
        chk_val("err_cnt", 32'(err_a), 32'(e.err));
        chk_val("err_pulse", 32'(pulse_a), 32'(e.pulse));
        chk_val("err_sticky", 32'(sticky_a), 32'(e.sticky));
        chk_val("busy", 32'(busy_a), 32'(e.busy));
        chk_val("first_exp", 32'(fexp_a), 32'(e.fexp));
        chk_val("first_jk", 32'(fjk_a), 32'(e.fjk));
    endtask

    task automatic check_reset_vals(input string tag);
        chk_val({tag, "_check_cnt"}, 32'(chk_a), 32'd0);
        chk_val({tag, "_err_cnt"}, 32'(err_a), 32'd0);
        chk_val({tag, "_err_pulse"}, 32'(pulse_a), 32'd0);
        chk_val({tag, "_err_sticky"}, 32'(sticky_a), 32'd0);
        chk_val({tag, "_first_exp"}, 32'(fexp_a), 32'd0);
        chk_val({tag, "_first_jk"}, 32'(fjk_a), 32'd0);
        chk_val({tag, "_busy"}, 32'(busy_a), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        en_a = 1'b0; clr_a = 1'b0; jk_a = 2'b00; q_a = 1'b0; qb_a = 1'b1;
        en_h = 1'b1; clr_h = 1'b0; jk_h = 2'b00; q_h = 1'b0; qb_h = 1'b0;
        en_s = 1'b1; clr_s = 1'b0; jk_s = 2'b11; q_s = 1'b0; qb_s = 1'b1;
        q_ff = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b0;

        // halting and saturating instances run while the default one idles
        for (int i = 1; i <= 13; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) begin
                chk_val("halt_check_cnt", 32'(chk_h), 32'd1);
                chk_val("halt_err_cnt", 32'(err_h), 32'd1);
                chk_val("halt_pulse", 32'(pulse_h), 32'd1);
                chk_val("halt_busy", 32'(busy_h), 32'd0);
                chk_val("halt_sticky", 32'(sticky_h), 32'd1);
                chk_val("sat_check_cnt_1", 32'(chk_s), 32'd1);
                chk_val("sat_err_cnt_1", 32'(err_s), 32'd1);
                chk_val("idle_busy", 32'(busy_a), 32'd0);
            end
            if (i == 4) chk_val("halt_pulse_end", 32'(pulse_h), 32'd0);
            if (i == 8) begin
                chk_val("sat_check_cnt", 32'(chk_s), 32'd3);
                chk_val("sat_err_cnt", 32'(err_s), 32'd3);
                chk_val("sat_pulse", 32'(pulse_s), 32'd1);
            end
            if (i == 13) begin
                chk_val("halt_frozen_check", 32'(chk_h), 32'd1);
                chk_val("halt_frozen_err", 32'(err_h), 32'd1);
                chk_val("halt_frozen_busy", 32'(busy_h), 32'd0);
            end
        end

        // clean sequence 00,01,10,11,11 after one priming edge
        step(2'b00, 1'b1, 1'b0, 0);
        step(2'b00, 1'b1, 1'b0, 0);
        step(2'b01, 1'b1, 1'b0, 0);
        step(2'b10, 1'b1, 1'b0, 0);
        step(2'b11, 1'b1, 1'b0, 0);
        step(2'b11, 1'b1, 1'b0, 0);
        chk_val("clean_check_cnt", 32'(chk_a), 32'd4);
        chk_val("clean_err_cnt", 32'(err_a), 32'd0);
        chk_val("clean_sticky", 32'(sticky_a), 32'd0);

        // q forced low after SET
        step(2'b10, 1'b1, 1'b0, 1);
        step(2'b00, 1'b1, 1'b0, 0);
        chk_val("set_fault_pulse", 32'(pulse_a), 32'd1);
        chk_val("set_fault_err_cnt", 32'(err_a), 32'd1);
        chk_val("set_fault_first_jk", 32'(fjk_a), 32'd2);
        chk_val("set_fault_first_exp", 32'(fexp_a), 32'd1);
        step(2'b00, 1'b1, 1'b0, 0);
        chk_val("set_fault_pulse_end", 32'(pulse_a), 32'd0);

        // enable pause, then one SYNC edge before checks resume
        repeat (3) step(2'b01, 1'b0, 1'b0, 0);
        chk_val("pause_check_cnt", 32'(chk_a), 32'd7);
        step(2'b10, 1'b1, 1'b0, 0);
        chk_val("resync_check_cnt", 32'(chk_a), 32'd7);
        step(2'b11, 1'b1, 1'b0, 0);
        chk_val("resume_check_cnt", 32'(chk_a), 32'd8);
        chk_val("resume_err_cnt", 32'(err_a), 32'd1);

        // second mismatch leaves the first capture alone
        step(2'b01, 1'b1, 1'b0, 2);
        step(2'b00, 1'b1, 1'b0, 0);
        chk_val("second_err_cnt", 32'(err_a), 32'd2);
        chk_val("second_first_jk", 32'(fjk_a), 32'd2);

        // synchronous clear, then restart
        step(2'b00, 1'b1, 1'b1, 0);
        chk_val("clr_err_cnt", 32'(err_a), 32'd0);
        step(2'b00, 1'b1, 1'b0, 0);
        step(2'b11, 1'b1, 1'b0, 0);
        step(2'b11, 1'b1, 1'b0, 0);
        chk_val("restart_check_cnt", 32'(chk_a), 32'd1);

        // asynchronous reset between edges while checking
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("async_rst");
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
